// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester backing-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive D grants taken while I was waiting; force_i lets I win the next arbitration.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant_i,
  input  logic             grant_d,
  input  logic             i_req,
  output logic             force_i,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (grant_i) begin
      cnt <= '0;
    end else if (grant_d) begin
      if (!i_req)          cnt <= '0;
      else if (cnt != LIMIT) cnt <= cnt + 1'b1;
    end
  end

  assign force_i = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single backing-memory port between I-side refill and D-side miss/write traffic.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  arb_owner_t       owner;
  logic             discard;
  logic             force_i;
  logic             grant_i;
  logic             grant_d;
  logic [CNT_W-1:0] starve_cnt;

  // D has priority unless I has been passed over STARVE_LIMIT times in a row.
  assign grant_d = (state == IDLE) && d_req && !(i_req && force_i);
  assign grant_i = (state == IDLE) && i_req && !grant_d;

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .grant_i (grant_i),
    .grant_d (grant_d),
    .i_req   (i_req),
    .force_i (force_i),
    .cnt     (starve_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_D;
      discard   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner     <= OWN_D;
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            state     <= BUSY;
          end else if (grant_i) begin
            owner     <= OWN_I;
            mem_addr  <= i_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (owner == OWN_I && flush) discard <= 1'b0 | 1'b1;
          if (mem_ready) begin
            state <= DONE;
            if (owner == OWN_D)         d_rdata <= mem_rdata;
            else if (!discard && !flush) i_rdata <= mem_rdata;
          end
        end
        DONE: begin
          state   <= IDLE;
          discard <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in the DONE cycle still squashes the I-side pulse.
  assign mem_valid = (state == BUSY);
  assign i_done    = (state == DONE) && (owner == OWN_I) && !discard && !flush;
  assign d_done    = (state == DONE) && (owner == OWN_D);
  assign i_stall   = i_req && !i_done;
  assign d_stall   = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, priority, starvation, flush, reset, zero-wait.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic tie_ready;
  logic ready_drv;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  assign mem_ready = tie_ready ? mem_valid : ready_drv;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_we      (d_we),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; tie_ready = 1'b0; ready_drv = 1'b0; mem_rdata = '0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_i_done", {31'd0, i_done}, 32'd0);
    check("rst_d_done", {31'd0, d_done}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Single I read, mem_ready two cycles after mem_valid
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    check("t1_valid", {31'd0, mem_valid}, 32'd1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_we", {31'd0, mem_we}, 32'd0);
    check("t1_istall", {31'd0, i_stall}, 32'd1);
    tick();
    check("t1_valid_hold", {31'd0, mem_valid}, 32'd1);
    tick();
    ready_drv = 1'b1; mem_rdata = 32'hDEADBEEF;
    check("t1_no_early_done", {31'd0, i_done}, 32'd0);
    tick();
    ready_drv = 1'b0; mem_rdata = '0;
    check("t1_i_done", {31'd0, i_done}, 32'd1);
    check("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    check("t1_istall_low", {31'd0, i_stall}, 32'd0);
    check("t1_valid_low", {31'd0, mem_valid}, 32'd0);
    i_req = 1'b0;
    tick();
    check("t1_done_pulse", {31'd0, i_done}, 32'd0);

    // Simultaneous requests: D write goes first
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b1; d_wdata = 32'h55;
    tick();
    check("t2_d_addr", mem_addr, 32'h200);
    check("t2_d_we", {31'd0, mem_we}, 32'd1);
    check("t2_d_wdata", mem_wdata, 32'h55);
    check("t2_istall", {31'd0, i_stall}, 32'd1);
    ready_drv = 1'b1;
    tick();
    ready_drv = 1'b0;
    check("t2_d_done", {31'd0, d_done}, 32'd1);
    check("t2_no_i_done", {31'd0, i_done}, 32'd0);
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    tick();
    check("t2_idle_gap", {31'd0, mem_valid}, 32'd0);
    tick();
    check("t2_i_addr", mem_addr, 32'h300);
    check("t2_i_we", {31'd0, mem_we}, 32'd0);
    ready_drv = 1'b1; mem_rdata = 32'h12345678;
    tick();
    ready_drv = 1'b0;
    check("t2_i_done", {31'd0, i_done}, 32'd1);
    check("t2_i_rdata", i_rdata, 32'h12345678);
    i_req = 1'b0;
    tick();

    // Starvation: four D grants while I waits, then I is forced through
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_addr = 32'h500; d_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_d_grant", mem_addr, 32'h500);
      ready_drv = 1'b1; mem_rdata = k;
      tick();
      ready_drv = 1'b0;
      check("t3_d_done", {31'd0, d_done}, 32'd1);
      check("t3_d_rdata", d_rdata, k);
      tick();
      check("t3_cnt", {29'd0, dut.starve_cnt}, k + 1);
    end
    tick();
    check("t3_i_forced", mem_addr, 32'h400);
    check("t3_cnt_clear", {29'd0, dut.starve_cnt}, 32'd0);
    ready_drv = 1'b1; mem_rdata = 32'hCAFE0000;
    tick();
    ready_drv = 1'b0;
    check("t3_i_done", {31'd0, i_done}, 32'd1);
    check("t3_i_rdata", i_rdata, 32'hCAFE0000);
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Flush during an I transaction
    i_req = 1'b1; i_addr = 32'h600;
    tick();
    check("t4_valid", {31'd0, mem_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; ready_drv = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    ready_drv = 1'b0;
    check("t4_no_i_done", {31'd0, i_done}, 32'd0);
    check("t4_rdata_kept", i_rdata, 32'hCAFE0000);
    check("t4_consumed", {31'd0, mem_valid}, 32'd0);
    i_req = 1'b0;
    d_req = 1'b1; d_addr = 32'h700; d_we = 1'b0;
    tick();
    check("t4_idle", {31'd0, mem_valid}, 32'd0);
    tick();
    check("t4_d_addr", mem_addr, 32'h700);
    ready_drv = 1'b1; mem_rdata = 32'h0D0D0D0D;
    tick();
    ready_drv = 1'b0;
    check("t4_d_done", {31'd0, d_done}, 32'd1);
    check("t4_d_rdata", d_rdata, 32'h0D0D0D0D);
    d_req = 1'b0;
    tick();

    // Asynchronous reset mid-BUSY, late mem_ready ignored
    d_req = 1'b1; d_addr = 32'h800; d_we = 1'b1; d_wdata = 32'h77;
    tick();
    check("t5_valid", {31'd0, mem_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_async_valid", {31'd0, mem_valid}, 32'd0);
    check("t5_async_addr", mem_addr, 32'd0);
    check("t5_async_wdata", mem_wdata, 32'd0);
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    tick();
    rst = 1'b1; ready_drv = 1'b1;
    tick();
    ready_drv = 1'b0;
    check("t5_ignored_ready", {31'd0, mem_valid}, 32'd0);
    check("t5_no_d_done", {31'd0, d_done}, 32'd0);
    check("t5_no_i_done", {31'd0, i_done}, 32'd0);
    check("t5_i_rdata_clr", i_rdata, 32'd0);
    check("t5_d_rdata_clr", d_rdata, 32'd0);
    tick();
    check("t5_still_idle", {31'd0, mem_valid | d_done}, 32'd0);

    // Zero-wait memory: 3-cycle request-to-done and back-to-back D
    tie_ready = 1'b1; mem_rdata = 32'h5A5A5A5A;
    i_req = 1'b1; i_addr = 32'h900;
    tick();
    check("t6_valid", {31'd0, mem_valid}, 32'd1);
    check("t6_addr", mem_addr, 32'h900);
    check("t6_istall_hi", {31'd0, i_stall}, 32'd1);
    check("t6_no_done", {31'd0, i_done}, 32'd0);
    tick();
    check("t6_i_done", {31'd0, i_done}, 32'd1);
    check("t6_i_rdata", i_rdata, 32'h5A5A5A5A);
    check("t6_istall_lo", {31'd0, i_stall}, 32'd0);
    i_req = 1'b0;
    d_req = 1'b1; d_addr = 32'hB00; d_we = 1'b0;
    tick();
    check("t6_idle_istall", {31'd0, i_stall}, 32'd0);
    check("t6_idle_dstall", {31'd0, d_stall}, 32'd1);
    tick();
    check("t6_d_busy", mem_addr, 32'hB00);
    check("t6_dstall_busy", {31'd0, d_stall}, 32'd1);
    mem_rdata = 32'h11112222;
    tick();
    check("t6_d_done1", {31'd0, d_done}, 32'd1);
    check("t6_d_rdata1", d_rdata, 32'h11112222);
    check("t6_dstall_done", {31'd0, d_stall}, 32'd0);
    tick();
    check("t6_rereq_idle", {31'd0, mem_valid}, 32'd0);
    check("t6_rereq_stall", {31'd0, d_stall}, 32'd1);
    mem_rdata = 32'h33334444;
    tick();
    check("t6_d_busy2", {31'd0, mem_valid}, 32'd1);
    tick();
    check("t6_d_done2", {31'd0, d_done}, 32'd1);
    check("t6_d_rdata2", d_rdata, 32'h33334444);
    d_req = 1'b0;
    tick();
    check("t6_final_idle", {31'd0, d_stall | d_done | mem_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
